// File: rtl/decode_arith_pkg.sv
// decode_arith_pkg: shared widths, state encoding and saturation value for the decode arithmetic units
package decode_arith_pkg;
    localparam int DIVIDEND_W = 30;
    localparam int DIVISOR_W  = 15;
    localparam int QUOT_W     = 15;
    localparam int CNT_W      = $clog2(QUOT_W);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(QUOT_W - 1);
    localparam logic [QUOT_W-1:0] QUOT_SAT = 15'h7FFF;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/decode_udiv_step.sv
// decode_udiv_step: one restoring-division bit (shift in, trial subtract, restore)
module decode_udiv_step
    import decode_arith_pkg::*;
#(
    parameter int W = DIVISOR_W
) (
    input  logic [W-1:0] r,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_next,
    output logic         qbit
);
    logic [W:0] t;
    logic [W:0] diff;
    // since r < divisor, t < 2*divisor and the difference always fits in W bits
    always_comb begin
        t      = {r, msb};
        diff   = t - {1'b0, divisor};
        qbit   = t >= {1'b0, divisor};
        r_next = qbit ? diff[W-1:0] : t[W-1:0];
    end
endmodule

// File: rtl/decode_udiv_30ns_15ns_15_seq.sv
// decode_udiv_30ns_15ns_15_seq: radix-2 restoring 30/15 divider with start/done handshake and ce stall
module decode_udiv_30ns_15ns_15_seq
    import decode_arith_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     dout,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  div_by_zero,
    output logic                  overflow
);
    state_t state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIVISOR_W-1:0] div_q, div_d, r_q, r_d, r_nx, rem_q, rem_d;
    logic [QUOT_W-1:0]    sh_q, sh_d, dout_q, dout_d;
    logic                 dbz_q, dbz_d, ovf_q, ovf_d;
    logic                 qbit, accept, step, zero_div, ovf_div;

    assign accept   = ce & start & (state_q != CALC);
    assign step     = ce & (state_q == CALC);
    assign zero_div = din1 == '0;
    assign ovf_div  = din0[DIVIDEND_W-1:QUOT_W] >= din1;

    // shift register starts as the dividend low half and fills with quotient bits from the LSB
    decode_udiv_step #(.W(DIVISOR_W)) u_step (
        .r       (r_q),
        .msb     (sh_q[QUOT_W-1]),
        .divisor (div_q),
        .r_next  (r_nx),
        .qbit    (qbit)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: error cases finish in one edge, DONE falls back to IDLE without a new start
    always_comb begin
        state_d = state_q;
        if (ce) begin
            if (state_q == CALC) state_d = (cnt_q == '0) ? DONE : CALC;
            else                 state_d = start ? ((zero_div || ovf_div) ? DONE : CALC) : IDLE;
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        busy = state_q == CALC;
        done = state_q == DONE;
    end

    // datapath next values: operand load on accept, one quotient bit per enabled CALC edge
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        r_d    = r_q;
        sh_d   = sh_q;
        dout_d = dout_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        if (accept) begin
            div_d = din1;
            dbz_d = zero_div;
            ovf_d = !zero_div && ovf_div;
            if (zero_div) begin
                dout_d = QUOT_SAT;
                rem_d  = '0;
            end else if (ovf_div) begin
                dout_d = QUOT_SAT;
                rem_d  = din0[QUOT_W-1:0];
            end else begin
                r_d   = din0[DIVIDEND_W-1:QUOT_W];
                sh_d  = din0[QUOT_W-1:0];
                cnt_d = CNT_INIT;
            end
        end else if (step) begin
            r_d    = r_nx;
            sh_d   = {sh_q[QUOT_W-2:0], qbit};
            cnt_d  = cnt_q - 1'b1;
            dout_d = (cnt_q == '0) ? {sh_q[QUOT_W-2:0], qbit} : dout_q;
            rem_d  = (cnt_q == '0) ? r_nx : rem_q;
        end
    end

    // datapath registers, all cleared by reset so no partial result survives it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= '0;
            r_q    <= '0;
            sh_q   <= '0;
            dout_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            r_q    <= r_d;
            sh_q   <= sh_d;
            dout_q <= dout_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout        = dout_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_decode_udiv_30ns_15ns_15_seq.sv
// tb_decode_udiv_30ns_15ns_15_seq: vector table, ce/reset corner sequences and randomized model check
module tb_decode_udiv_30ns_15ns_15_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [29:0] din0 = '0;
    logic [14:0] din1 = '0;
    logic        busy, done, div_by_zero, overflow;
    logic [14:0] dout, rem;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [14:0] q;
        logic [14:0] r;
        logic        dz;
        logic        ov;
        int          n;
        int          bc;
    } res_t;

    typedef struct {
        logic [29:0] a;
        logic [14:0] b;
        logic [14:0] q;
        logic [14:0] r;
        logic        dz;
        logic        ov;
        int          n;
    } vec_t;

    decode_udiv_30ns_15ns_15_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    endtask

    // n counts falling edges after the start was driven, the accept edge being the first
    task automatic run_div(input logic [29:0] a, input logic [14:0] b, output res_t o);
        start = 1'b1;
        din0 = a;
        din1 = b;
        ce = 1'b1;
        o.bc = 0;
        @(negedge clk);
        start = 1'b0;
        o.n = 1;
        while (!done && o.n < 100) begin
            if (busy) o.bc++;
            @(negedge clk);
            o.n++;
        end
        o.q = dout;
        o.r = rem;
        o.dz = div_by_zero;
        o.ov = overflow;
    endtask

    function automatic logic [63:0] pack(input res_t o);
        return {o.q, o.r, o.dz, o.ov, 32'(o.n)};
    endfunction

    // reference: plain integer division with the saturation rules for zero divisor and wide quotient
    function automatic logic [63:0] model(input logic [29:0] a, input logic [14:0] b);
        logic [63:0] qq, rr;
        if (b == 0) return {15'h7FFF, 15'h0, 1'b1, 1'b0, 32'd1};
        if ((64'(a) >> 15) >= 64'(b)) return {15'h7FFF, a[14:0], 1'b0, 1'b1, 32'd1};
        qq = 64'(a) / 64'(b);
        rr = 64'(a) % 64'(b);
        return {qq[14:0], rr[14:0], 1'b0, 1'b0, 32'd16};
    endfunction

    initial begin
        vec_t tv[7];
        res_t o;
        int n, cnt;
        logic [14:0] q0;
        tv[0] = '{30'd83810205,   15'd6789,  15'd12345,  15'd0,     1'b0, 1'b0, 16};
        tv[1] = '{30'd100000000,  15'd32767, 15'd3051,   15'd27883, 1'b0, 1'b0, 16};
        tv[2] = '{30'd1234,       15'd0,     15'h7FFF,   15'd0,     1'b1, 1'b0, 1};
        tv[3] = '{30'h3FFFFFFF,   15'd1,     15'h7FFF,   15'h7FFF,  1'b0, 1'b1, 1};
        tv[4] = '{30'd1073709055, 15'd32767, 15'h7FFF,   15'h7FFE,  1'b0, 1'b0, 16};
        tv[5] = '{30'd163840,     15'd5,     15'h7FFF,   15'd0,     1'b0, 1'b1, 1};
        tv[6] = '{30'd0,          15'd1,     15'd0,      15'd0,     1'b0, 1'b0, 16};

        #2 reset = 1'b1;
        #1 check("reset_state", {busy, done, dout, rem, div_by_zero, overflow}, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_div(tv[i].a, tv[i].b, o);
            check($sformatf("vec%0d", i), pack(o), {tv[i].q, tv[i].r, tv[i].dz, tv[i].ov, 32'(tv[i].n)});
            check($sformatf("vec%0d_busy_cycles", i), 64'(o.bc), 64'(tv[i].n == 16 ? 15 : 0));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {done, busy}, 2'b00);
        end

        start = 1'b1;
        din0 = 30'd83810205;
        din1 = 15'd6789;
        ce = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        ce = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            start = (n == 10);
            din0 = (n == 10) ? 30'd5000 : 30'd83810205;
            din1 = (n == 10) ? 15'd7 : 15'd6789;
            if (!done) ce = ~ce;
        end
        start = 1'b0;
        check("ce_toggle_latency", 64'(n), 64'd31);
        check("ce_toggle_result", {dout, rem, div_by_zero, overflow}, {15'd12345, 15'd0, 2'b00});
        ce = 1'b0;
        @(negedge clk);
        check("done_held_by_ce", {done, dout}, {1'b1, 15'd12345});
        ce = 1'b1;
        @(negedge clk);
        check("done_after_ce", done, 1'b0);

        start = 1'b1;
        din0 = 30'd83810205;
        din1 = 15'd6789;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_reset_mid", {busy, done, dout, rem, div_by_zero, overflow}, '0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("no_result_after_reset", 64'(cnt), 64'd0);

        run_div(30'd100000000, 15'd32767, o);
        check("post_reset_case2", pack(o), {15'd3051, 15'd27883, 2'b00, 32'd16});
        check("post_reset_busy", 64'(o.bc), 64'd15);
        run_div(30'd83810205, 15'd6789, o);
        check("back_to_back", pack(o), {15'd12345, 15'd0, 2'b00, 32'd16});
        check("back_to_back_busy", 64'(o.bc), 64'd15);

        for (int i = 0; i < 2000; i++) begin
            logic [29:0] a;
            logic [14:0] b;
            int mode;
            mode = $urandom_range(0, 7);
            b = (mode == 0) ? 15'd0 : 15'($urandom_range(1, 32767));
            if (mode == 1) a = {15'($urandom_range(int'(b), 32767)), 15'($urandom)};
            else if (mode == 0) a = 30'($urandom);
            else a = {15'($urandom_range(0, int'(b) - 1)), 15'($urandom)};
            run_div(a, b, o);
            check($sformatf("rand%0d a=%0d b=%0d", i, a, b), pack(o), model(a, b));
            if (mode > 1) begin
                check($sformatf("rand%0d_invariant", i), 64'(o.q) * 64'(b) + 64'(o.r), 64'(a));
                check($sformatf("rand%0d_rem_lt", i), o.r < b, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
